// File: rtl/du_scaled_dbuf.sv
// ============================================================================
// Module      : du_scaled_dbuf
// Description : Display timing, integer-upscaled centred canvas addressing and
//               tear-free double-buffer swap between VRAM and the VGA pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module du_scaled_dbuf #(
    parameter int          DW       = 16,
    parameter int          H_LEN    = 200,
    parameter int          V_LEN    = 150,
    parameter int          SCALE    = 4,
    parameter int          H_ACT    = 800,
    parameter int          H_FP     = 56,
    parameter int          H_SW     = 120,
    parameter int          H_BP     = 64,
    parameter int          V_ACT    = 600,
    parameter int          V_FP     = 37,
    parameter int          V_SW     = 6,
    parameter int          V_BP     = 23,
    parameter int          SYNC_POL = 1,
    parameter int          RD_LAT   = 1,
    parameter logic [11:0] BORDER   = 12'h000
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic [11:0]   rdata,
    input  logic          swap_req,
    output logic [DW-1:0] raddr,
    output logic [11:0]   rgb,
    output logic          hs,
    output logic          vs,
    output logic          vblank,
    output logic          frame_start,
    output logic          front,
    output logic          swap_ack
);

    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SUBW  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int H_OFF = (H_ACT - H_LEN * SCALE) / 2;
    localparam int V_OFF = (V_ACT - V_LEN * SCALE) / 2;

    localparam logic [HW-1:0]   H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0]   H_ACT_C  = HW'(H_ACT);
    localparam logic [HW-1:0]   HS_BEG   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0]   HS_END   = HW'(H_ACT + H_FP + H_SW);
    localparam logic [HW-1:0]   H_CB     = HW'(H_OFF);
    localparam logic [HW-1:0]   H_CW     = HW'(H_LEN * SCALE);
    localparam logic [VW-1:0]   V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0]   V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0]   V_LASTA  = VW'(V_ACT - 1);
    localparam logic [VW-1:0]   VS_BEG   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0]   VS_END   = VW'(V_ACT + V_FP + V_SW);
    localparam logic [VW-1:0]   V_CB     = VW'(V_OFF);
    localparam logic [VW-1:0]   V_CW     = VW'(V_LEN * SCALE);
    localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SCALE - 1);
    localparam logic [DW-1:0]   LINE_INC = DW'(H_LEN);
    localparam logic [DW-1:0]   FB_OFF   = DW'(H_LEN * V_LEN);
    localparam logic            POL      = (SYNC_POL != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } swap_state_t;

    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [VW-1:0]          vcnt_q, vcnt_d;
    logic [SUBW-1:0]        hsub_q, hsub_d, vsub_q, vsub_d;
    logic [DW-1:0]          x_q, x_d, ybase_q, ybase_d;
    logic [DW-1:0]          raddr_q, raddr_d;
    logic [RD_LAT:0][5:0]   dl_q, dl_d;
    logic [11:0]            rgb_q, rgb_d;
    logic                   hs_q, vs_q, vblank_q, fs_q;
    swap_state_t            sw_q, sw_d;
    logic                   front_q, front_d, ack_q, ack_d;

    logic [HW-1:0] hrel;
    logic [VW-1:0] vrel;
    logic          line_end, frame_end, swap_pt;
    logic          hin, vin, de0, inc0, hsr0, vsr0, vb0, fs0;
    logic          de_o, inc_o, hsr_o, vsr_o, vb_o, fs_o;

    // Stage 0: everything decoded straight from the counters
    always_comb begin
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);
        swap_pt   = line_end && (vcnt_q == V_LASTA);
        hrel      = hcnt_q - H_CB;
        vrel      = vcnt_q - V_CB;
        hin       = (hrel < H_CW);
        vin       = (vrel < V_CW);
        de0       = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        inc0      = hin && vin;
        hsr0      = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vsr0      = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        vb0       = (vcnt_q >= V_ACT_C);
        fs0       = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Sub-pixel counters step x / line base every SCALE pixels / lines
    always_comb begin
        hcnt_d  = line_end ? '0 : hcnt_q + 1'b1;
        vcnt_d  = vcnt_q;
        hsub_d  = hsub_q;
        x_d     = x_q;
        vsub_d  = vsub_q;
        ybase_d = ybase_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            hsub_d = '0;
            x_d    = '0;
            if (frame_end) begin
                vsub_d  = '0;
                ybase_d = '0;
            end else if (vin) begin
                if (vsub_q == SUB_LAST) begin
                    vsub_d  = '0;
                    ybase_d = ybase_q + LINE_INC;
                end else begin
                    vsub_d = vsub_q + 1'b1;
                end
            end
        end else if (hin) begin
            if (hsub_q == SUB_LAST) begin
                hsub_d = '0;
                x_d    = x_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
            end
        end
        raddr_d = inc0 ? ((front_q ? FB_OFF : '0) + ybase_q + x_q) : raddr_q;
    end

    always_comb begin
        sw_d    = sw_q;
        front_d = front_q;
        ack_d   = 1'b0;
        case (sw_q)
            S_IDLE: begin
                if (swap_req) begin
                    if (swap_pt) begin
                        front_d = ~front_q;
                        ack_d   = 1'b1;
                    end else begin
                        sw_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (swap_pt) begin
                    front_d = ~front_q;
                    ack_d   = 1'b1;
                    sw_d    = S_IDLE;
                end
            end
            default: sw_d = S_IDLE;
        endcase
    end

    // Flags wait RD_LAT+1 cycles so they meet the VRAM data at the output register
    always_comb begin
        dl_d  = {dl_q[RD_LAT-1:0], {de0, inc0, hsr0, vsr0, vb0, fs0}};
        de_o  = dl_q[RD_LAT][5];
        inc_o = dl_q[RD_LAT][4];
        hsr_o = dl_q[RD_LAT][3];
        vsr_o = dl_q[RD_LAT][2];
        vb_o  = dl_q[RD_LAT][1];
        fs_o  = dl_q[RD_LAT][0];
        rgb_d = 12'h000;
        if (de_o) begin
            rgb_d = inc_o ? rdata : BORDER;
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hsub_q   <= '0;
            vsub_q   <= '0;
            x_q      <= '0;
            ybase_q  <= '0;
            raddr_q  <= '0;
            dl_q     <= '0;
            rgb_q    <= 12'h000;
            hs_q     <= ~POL;
            vs_q     <= ~POL;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
            sw_q     <= S_IDLE;
            front_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hsub_q   <= hsub_d;
            vsub_q   <= vsub_d;
            x_q      <= x_d;
            ybase_q  <= ybase_d;
            raddr_q  <= raddr_d;
            dl_q     <= dl_d;
            rgb_q    <= rgb_d;
            hs_q     <= ~(hsr_o ^ POL);
            vs_q     <= ~(vsr_o ^ POL);
            vblank_q <= vb_o;
            fs_q     <= fs_o;
            sw_q     <= sw_d;
            front_q  <= front_d;
            ack_q    <= ack_d;
        end
    end

    assign raddr       = raddr_q;
    assign rgb         = rgb_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vblank      = vblank_q;
    assign frame_start = fs_q;
    assign front       = front_q;
    assign swap_ack    = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_du_scaled_dbuf.sv
// ============================================================================
// Module      : tb_du_scaled_dbuf
// Description : Three shrunk-timing instances (different SCALE, RD_LAT,
//               polarity, border) checked against a frame-position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_du_scaled_dbuf;

    localparam int NI   = 3;
    localparam int T_HA = 20, T_HF = 3, T_HS = 4, T_HB = 5;
    localparam int T_VA = 14, T_VF = 2, T_VS = 2, T_VB = 3;
    localparam int HT   = T_HA + T_HF + T_HS + T_HB;
    localparam int VT   = T_VA + T_VF + T_VS + T_VB;
    localparam int FT   = HT * VT;

    localparam int          C_HL  [NI] = '{8, 5, 10};
    localparam int          C_VL  [NI] = '{6, 4, 7};
    localparam int          C_S   [NI] = '{2, 3, 2};
    localparam int          C_RL  [NI] = '{1, 3, 2};
    localparam int          C_POL [NI] = '{1, 0, 1};
    localparam logic [11:0] C_BD  [NI] = '{12'h0F0, 12'hF00, 12'h00F};

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vb;
        logic        fs;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rstn = 1'b0;
    logic        swap_req = 1'b0;
    logic [7:0]  raddr_w [NI];
    logic [11:0] rgb_w   [NI];
    logic [11:0] rdata_w [NI];
    logic        hs_w [NI], vs_w [NI], vb_w [NI], fs_w [NI], fr_w [NI], ack_w [NI];
    logic [7:0]  mp [NI][3];

    int nchk = 0;
    int nerr = 0;
    int scyc = 0;

    always #5 pclk = ~pclk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        du_scaled_dbuf #(
            .DW(8), .H_LEN(C_HL[gi]), .V_LEN(C_VL[gi]), .SCALE(C_S[gi]),
            .H_ACT(T_HA), .H_FP(T_HF), .H_SW(T_HS), .H_BP(T_HB),
            .V_ACT(T_VA), .V_FP(T_VF), .V_SW(T_VS), .V_BP(T_VB),
            .SYNC_POL(C_POL[gi]), .RD_LAT(C_RL[gi]), .BORDER(C_BD[gi])
        ) u_dut (
            .pclk(pclk), .rstn(rstn), .rdata(rdata_w[gi]), .swap_req(swap_req),
            .raddr(raddr_w[gi]), .rgb(rgb_w[gi]), .hs(hs_w[gi]), .vs(vs_w[gi]),
            .vblank(vb_w[gi]), .frame_start(fs_w[gi]), .front(fr_w[gi]),
            .swap_ack(ack_w[gi])
        );
    end

    // VRAM model: data is the low address bits, returned RD_LAT cycles later
    always @(posedge pclk) begin
        for (int i = 0; i < NI; i++) begin
            mp[i][0] <= raddr_w[i];
            mp[i][1] <= mp[i][0];
            mp[i][2] <= mp[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rdata_w[i] = {4'h0, mp[i][C_RL[i]-1]};
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Model state: t = rising edges since reset release
    int         t;
    logic       pend, fr_m, ack_m;
    logic [7:0] ra_m [NI];
    exp_t       hist [NI][8];

    initial begin : p_compare
        int   p, h, v, s, hoff, voff, addr, lat;
        logic pol, de, inc, swp;
        exp_t e;
        t = 0; pend = 1'b0; fr_m = 1'b0; ack_m = 1'b0;
        for (int i = 0; i < NI; i++) ra_m[i] = 8'h00;
        forever begin
            @(negedge pclk);
            if (!rstn) begin
                t = 0; pend = 1'b0; fr_m = 1'b0; ack_m = 1'b0;
                for (int i = 0; i < NI; i++) ra_m[i] = 8'h00;
            end
            for (int i = 0; i < NI; i++) begin
                pol = (C_POL[i] != 0);
                lat = C_RL[i] + 2;
                e   = (t >= lat) ? hist[i][(t - lat) % 8] : {12'h000, ~pol, ~pol, 1'b0, 1'b0};
                chk("rgb",         i, 32'(rgb_w[i]),   32'(e.rgb));
                chk("hs",          i, 32'(hs_w[i]),    32'(e.hs));
                chk("vs",          i, 32'(vs_w[i]),    32'(e.vs));
                chk("vblank",      i, 32'(vb_w[i]),    32'(e.vb));
                chk("frame_start", i, 32'(fs_w[i]),    32'(e.fs));
                chk("raddr",       i, 32'(raddr_w[i]), 32'(ra_m[i]));
                chk("front",       i, 32'(fr_w[i]),    32'(fr_m));
                chk("swap_ack",    i, 32'(ack_w[i]),   32'(ack_m));
            end
            p = t % FT;
            h = p % HT;
            v = p / HT;
            for (int i = 0; i < NI; i++) begin
                pol  = (C_POL[i] != 0);
                s    = C_S[i];
                hoff = (T_HA - C_HL[i] * s) / 2;
                voff = (T_VA - C_VL[i] * s) / 2;
                de   = (h < T_HA) && (v < T_VA);
                inc  = (h >= hoff) && (h < hoff + C_HL[i] * s) &&
                       (v >= voff) && (v < voff + C_VL[i] * s);
                addr = (fr_m ? C_HL[i] * C_VL[i] : 0) + ((v - voff) / s) * C_HL[i] + (h - hoff) / s;
                if (inc) ra_m[i] = addr[7:0];
                e.rgb = de ? (inc ? 12'(addr) : C_BD[i]) : 12'h000;
                e.hs  = (h >= T_HA + T_HF && h < T_HA + T_HF + T_HS) ? pol : ~pol;
                e.vs  = (v >= T_VA + T_VF && v < T_VA + T_VF + T_VS) ? pol : ~pol;
                e.vb  = (v >= T_VA);
                e.fs  = (h == 0) && (v == 0);
                hist[i][t % 8] = e;
            end
            swp   = (h == HT - 1) && (v == T_VA - 1) && (pend || swap_req);
            ack_m = swp;
            if (swp) begin
                fr_m = ~fr_m;
                pend = 1'b0;
            end else if (swap_req) begin
                pend = 1'b1;
            end
            t++;
        end
    end

    task automatic step();
        @(posedge pclk);
        scyc++;
        #1;
    endtask

    task automatic go(input int n);
        while (scyc < n) step();
    endtask

    task automatic pulse(input int n);
        go(n);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    initial begin : p_stim
        repeat (3) @(negedge pclk);
        chk("rst_hs_b", 1, 32'(hs_w[1]), 32'd1);
        chk("rst_hs_a", 0, 32'(hs_w[0]), 32'd0);
        chk("rst_raddr", 0, 32'(raddr_w[0]), 32'd0);
        @(negedge pclk);
        #1 rstn = 1'b1;
        scyc = 0;

        go(25);  chk("hs_first_pre", 0, 32'(hs_w[0]), 32'd0);
        go(26);  chk("hs_first", 0, 32'(hs_w[0]), 32'd1);
        go(27);  chk("hs_first", 2, 32'(hs_w[2]), 32'd1);
        go(28);  chk("hs_first_lo", 1, 32'(hs_w[1]), 32'd0);
        go(102); chk("raddr_x1y1", 0, 32'(raddr_w[0]), 32'd9);
        go(138); chk("rgb_canvas", 1, 32'(rgb_w[1]), 32'h006);
        go(165); chk("rgb_border", 1, 32'(rgb_w[1]), 32'hF00);
        pulse(7 * HT + 4);
        go(402); chk("raddr_last", 0, 32'(raddr_w[0]), 32'd47);
        go(403); chk("raddr_hold", 0, 32'(raddr_w[0]), 32'd47);
        go(447); chk("ack_pre", 0, 32'(ack_w[0]), 32'd0);
        go(448); chk("ack", 0, 32'(ack_w[0]), 32'd1);
                 chk("front_swapped", 0, 32'(fr_w[0]), 32'd1);
        go(516); chk("vs_pre", 1, 32'(vs_w[1]), 32'd1);
        go(517); chk("vs_first", 1, 32'(vs_w[1]), 32'd0);
        go(FT + HT + 3); chk("raddr_back_buf", 0, 32'(raddr_w[0]), 32'd48);

        // two requests in one frame
        pulse(FT + 2 * HT);
        pulse(FT + 6 * HT);
        go(FT + 448); chk("front_double", 0, 32'(fr_w[0]), 32'd0);
        // request exactly on the swap cycle
        pulse(2 * FT + 447);
        go(2 * FT + 448); chk("front_coinc", 0, 32'(fr_w[0]), 32'd1);
        // pending request plus a coincident one
        pulse(3 * FT + 3 * HT);
        pulse(3 * FT + 447);
        go(3 * FT + 448); chk("front_pend_coinc", 0, 32'(fr_w[0]), 32'd0);
        go(3 * FT + 449); chk("ack_single", 0, 32'(ack_w[0]), 32'd0);
        pulse(4 * FT + 5 * HT);
        go(4 * FT + 448); chk("front_again", 0, 32'(fr_w[0]), 32'd1);

        // asynchronous reset in the middle of a frame
        go(5 * FT + 8 * HT + 13);
        #2 rstn = 1'b0;
        #1;
        chk("arst_rgb",   0, 32'(rgb_w[0]),   32'h000);
        chk("arst_raddr", 0, 32'(raddr_w[0]), 32'd0);
        chk("arst_front", 0, 32'(fr_w[0]),    32'd0);
        chk("arst_hs",    1, 32'(hs_w[1]),    32'd1);
        chk("arst_vs",    1, 32'(vs_w[1]),    32'd1);
        repeat (4) @(negedge pclk);
        #1 rstn = 1'b1;
        scyc = 0;
        go(2); chk("fs_pre", 0, 32'(fs_w[0]), 32'd0);
        go(3); chk("fs_post_reset", 0, 32'(fs_w[0]), 32'd1);
        go(4); chk("fs_pulse_end", 0, 32'(fs_w[0]), 32'd0);
               chk("fs_post_reset", 2, 32'(fs_w[2]), 32'd1);
        pulse(5 * HT);
        go(448); chk("front_post_reset", 0, 32'(fr_w[0]), 32'd1);
        go(FT + 40);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

`default_nettype wire
